vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture_pkg.sv | 24 ++
 rtl/vga_sync_edge.sv | 38 +++
 rtl/vga_capture.sv | 183 ++++++++++++++++++
 tb/tb_vga_capture.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_capture_pkg.sv
// Shared types and constants for the VGA frame-capture block.
package vga_capture_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int ADDR_W       = 19;
  localparam int COORD_W      = 10;
  localparam int FCNT_W       = 16;
  localparam int PIX_W        = 24;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VSYNC,
    ST_FRAME,
    ST_IDLE
  } cap_state_t;

  // Coordinate counters stop at all-ones so a runaway line or frame can
  // never wrap back into the legal write window.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (&v) ? v : v + COORD_W'(1);
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers blank_n/vs once and derives one-cycle edge pulses from the
// registered copies.
module vga_sync_edge (
  input  logic vga_clk,
  input  logic reset,
  input  logic blank_n,
  input  logic vs,
  output logic blank_q,
  output logic vs_q,
  output logic blank_fall,
  output logic vs_fall,
  output logic vs_rise
);

  logic blank_d;
  logic vs_d;

  // Input register plus one history stage for edge detection.
  always_ff @(posedge vga_clk) begin
    // NOTE: non-blocking assignments so each stage samples the pre-edge value of the previous one.
    if (reset) begin
      blank_q <= 1'b0;
      blank_d <= 1'b0;
      vs_q    <= 1'b1;
      vs_d    <= 1'b1;
    end else begin
      blank_q <= blank_n;
      blank_d <= blank_q;
      vs_q    <= vs;
      vs_d    <= vs_q;
    end
  end

  assign blank_fall = blank_d & ~blank_q;
  assign vs_fall    = vs_d & ~vs_q;
  assign vs_rise    = ~vs_d & vs_q;

endmodule

// File: rtl/vga_capture.sv
// VGA frame capture: writes active pixels of a frame to a frame-buffer port.
// A pixel registered at edge k is driven on wr_* by edge k+1 and is taken
// by the frame buffer at edge k+2.
// Optional feature: define VGA_CAPTURE_CHECKSUM_EN to add frame_sum.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               blank_n,
  input  logic               vs,
  input  logic [7:0]         b_data,
  input  logic [7:0]         g_data,
  input  logic [7:0]         r_data,
  input  logic               capture_en,
  input  logic               err_clr,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIX_W-1:0]   wr_data,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_done,
  output logic [FCNT_W-1:0]  frame_count,
  output logic               line_err,
  output logic               frame_err
`ifdef VGA_CAPTURE_CHECKSUM_EN
  ,
  output logic [31:0]        frame_sum
`endif
);

  localparam logic [COORD_W-1:0] H_LIM  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM  = COORD_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0]  H_STEP = ADDR_W'(H_ACTIVE);

  cap_state_t state_q, state_d;

  logic               blank_q, vs_q, blank_fall, vs_fall, vs_rise;
  logic [PIX_W-1:0]   pix_q;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic [ADDR_W-1:0]  addr_cnt, line_base;
  logic               in_frame, zero_cnt, wr_go, frame_end;
  logic               line_err_set, frame_err_set;

  vga_sync_edge u_sync (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .blank_n    (blank_n),
    .vs         (vs),
    .blank_q    (blank_q),
    .vs_q       (vs_q),
    .blank_fall (blank_fall),
    .vs_fall    (vs_fall),
    .vs_rise    (vs_rise)
  );

  // Pixel colour register, aligned with the registered timing signals.
  always_ff @(posedge vga_clk) begin
    // NOTE: pure datapath register with no reset; it only reaches wr_data when wr_en is qualified.
    pix_q <= {b_data, g_data, r_data};
  end

  // FSM state register.
  always_ff @(posedge vga_clk) begin
    if (reset) state_q <= ST_SEARCH;
    else       state_q <= state_d;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d  = state_q;
    in_frame = 1'b0;
    zero_cnt = 1'b0;
    unique case (state_q)
      ST_SEARCH: if (!vs_q) state_d = ST_VSYNC;
      ST_VSYNC: begin
        zero_cnt = 1'b1;
        if (vs_rise) state_d = capture_en ? ST_FRAME : ST_IDLE;
      end
      ST_IDLE:   if (!vs_q) state_d = ST_VSYNC;
      ST_FRAME: begin
        in_frame = 1'b1;
        if (vs_fall) state_d = ST_VSYNC;
      end
      default:   state_d = ST_SEARCH;
    endcase

    wr_go         = in_frame & blank_q & (x_cnt < H_LIM) & (y_cnt < V_LIM);
    frame_end     = in_frame & vs_fall;
    line_err_set  = in_frame & ((blank_q & (x_cnt >= H_LIM)) |
                                (blank_fall & (x_cnt != H_LIM)));
    frame_err_set = in_frame & ((blank_q & (y_cnt >= V_LIM)) |
                                (vs_fall & (y_cnt != V_LIM)));
  end

  // Coordinate/address counters and the frame-buffer write port.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      addr_cnt    <= '0;
      line_base   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      x           <= '0;
      y           <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      wr_en      <= wr_go;
      frame_done <= frame_end;
      if (frame_end) frame_count <= frame_count + FCNT_W'(1);
      if (wr_go) begin
        wr_addr <= addr_cnt;
        wr_data <= pix_q;
        x       <= x_cnt;
        y       <= y_cnt;
      end
      if (zero_cnt) begin
        x_cnt     <= '0;
        y_cnt     <= '0;
        addr_cnt  <= '0;
        line_base <= '0;
        wr_addr   <= '0;
        x         <= '0;
        y         <= '0;
      end else if (in_frame) begin
        if (blank_fall) begin
          // Re-derive the address from the line base so a short or long
          // line cannot skew every following line.
          x_cnt     <= '0;
          y_cnt     <= sat_inc(y_cnt);
          line_base <= line_base + H_STEP;
          addr_cnt  <= line_base + H_STEP;
        end else if (blank_q) begin
          x_cnt    <= sat_inc(x_cnt);
          addr_cnt <= addr_cnt + ADDR_W'(1);
        end
      end
    end
  end

  // Sticky error flags; a fresh error outranks a clear in the same cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (line_err_set)  line_err  <= 1'b1;
      else if (err_clr)  line_err  <= 1'b0;
      if (frame_err_set) frame_err <= 1'b1;
      else if (err_clr)  frame_err <= 1'b0;
    end
  end

`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [31:0] sum_acc;
  logic [31:0] sum_next;

  assign sum_next = sum_acc + (wr_go ? {8'd0, pix_q} : 32'd0);

  // Running sum of written pixels, published together with frame_done.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else if (zero_cnt) begin
      sum_acc <= '0;
    end else if (frame_end) begin
      frame_sum <= sum_next;
      sum_acc   <= '0;
    end else begin
      sum_acc <= sum_next;
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture: randomized frames, a frame-level model
// that predicts writes/frame_done/error flags, and a monitor that compares.
module tb_vga_capture;

  localparam int H = 16;
  localparam int V = 12;

  logic        vga_clk = 1'b0;
  logic        reset, blank_n, vs, capture_en, err_clr;
  logic [7:0]  b_data, g_data, r_data;
  logic        wr_en, frame_done, line_err, frame_err;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic [9:0]  x, y;
  logic [15:0] frame_count;
`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [31:0] frame_sum;
`endif

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .blank_n     (blank_n),
    .vs          (vs),
    .b_data      (b_data),
    .g_data      (g_data),
    .r_data      (r_data),
    .capture_en  (capture_en),
    .err_clr     (err_clr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .x           (x),
    .y           (y),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .line_err    (line_err),
    .frame_err   (frame_err)
`ifdef VGA_CAPTURE_CHECKSUM_EN
    ,
    .frame_sum   (frame_sum)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
    logic [9:0]  xc;
    logic [9:0]  yc;
    int          due;
  } wr_exp_t;

  typedef struct {
    logic [15:0] cnt;
    logic [31:0] sum;
  } fd_exp_t;

  wr_exp_t wr_q[$];
  fd_exp_t fd_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every frame_done is matched against the queues.
  wr_exp_t mon_w;
  fd_exp_t mon_f;
  always @(negedge vga_clk) begin
    if (wr_en === 1'b1) begin
      if (wr_q.size() == 0) check("wr_en with no write expected", wr_en, 1'b0);
      else begin
        mon_w = wr_q.pop_front();
        check("wr_addr", wr_addr, mon_w.addr);
        check("wr_data", wr_data, mon_w.data);
        check("x",       x,       mon_w.xc);
        check("y",       y,       mon_w.yc);
        check("write latency", cyc, mon_w.due);
      end
    end
    if (frame_done === 1'b1) begin
      if (fd_q.size() == 0) check("frame_done with none expected", frame_done, 1'b0);
      else begin
        mon_f = fd_q.pop_front();
        check("frame_count at frame_done", frame_count, mon_f.cnt);
        check("writes pending at frame_done", wr_q.size(), 0);
`ifdef VGA_CAPTURE_CHECKSUM_EN
        check("frame_sum", frame_sum, mon_f.sum);
`endif
      end
    end
  end

  // Frame description consumed by run_frame.
  int          line_len[64];
  int          n_lines;
  int          clr_line;
  int          abort_line;
  bit          toggle_cap;
  bit          mark_pixel;
  bit          exp_lerr, exp_ferr;
  logic [15:0] fc_model = '0;

  task automatic tick();
    @(negedge vga_clk);
  endtask

  task automatic rand_pix();
    b_data = 8'($urandom);
    g_data = 8'($urandom);
    r_data = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " wr_en"},       wr_en,       1'b0);
    check({tag, " wr_addr"},     wr_addr,     19'd0);
    check({tag, " wr_data"},     wr_data,     24'd0);
    check({tag, " x"},           x,           10'd0);
    check({tag, " y"},           y,           10'd0);
    check({tag, " frame_done"},  frame_done,  1'b0);
    check({tag, " frame_count"}, frame_count, 16'd0);
    check({tag, " line_err"},    line_err,    1'b0);
    check({tag, " frame_err"},   frame_err,   1'b0);
  endtask

  task automatic set_uniform(input int lines, input int len);
    n_lines = lines;
    for (int i = 0; i < 64; i++) line_len[i] = len;
    clr_line = -1; abort_line = -1; toggle_cap = 0; mark_pixel = 0;
  endtask

  // vs low: closes the previous frame, then the flags are checked and cleared.
  task automatic end_frame();
    repeat (6) begin
      tick(); vs = 1'b0; blank_n = 1'b0; rand_pix();
    end
    check("line_err after frame",  line_err,  exp_lerr);
    check("frame_err after frame", frame_err, exp_ferr);
    check("wr_addr held in vsync", wr_addr,   19'd0);
    check("x held in vsync",       x,         10'd0);
    check("y held in vsync",       y,         10'd0);
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    check("line_err cleared",  line_err,  1'b0);
    check("frame_err cleared", frame_err, 1'b0);
    exp_lerr = 0; exp_ferr = 0;
  endtask

  task automatic run_frame(input bit cap);
    bit          live;
    bit          lerr, ferr;
    logic [31:0] sum;
    wr_exp_t     e;
    live = cap; lerr = 0; ferr = 0; sum = '0;
    tick(); vs = 1'b1; blank_n = 1'b0; capture_en = cap;
    repeat (2) begin tick(); rand_pix(); end
    for (int l = 0; l < n_lines; l++) begin
      if (l == abort_line) begin
        tick(); reset = 1'b1;
        tick();
        check_reset_outputs("mid-frame reset");
        reset = 1'b0;
        live = 0; lerr = 0; ferr = 0; fc_model = '0;
      end
      if (l == 2 && toggle_cap) capture_en = ~capture_en;
      for (int i = 0; i < line_len[l]; i++) begin
        tick(); blank_n = 1'b1; rand_pix();
        if (mark_pixel && l == 2 && i == 5) begin
          b_data = 8'h11; g_data = 8'h22; r_data = 8'h33;
        end
        if (live && l < V && i < H) begin
          e.addr = 19'(l * H + i);
          e.data = {b_data, g_data, r_data};
          e.xc   = 10'(i);
          e.yc   = 10'(l);
          e.due  = cyc + 2;
          wr_q.push_back(e);
          sum += {8'd0, e.data};
        end
      end
      if (live && line_len[l] != H) lerr = 1;
      tick(); blank_n = 1'b0; rand_pix();
      if (l == clr_line) begin
        tick(); err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        check("line_err kept over err_clr", line_err, 1'b1);
        lerr = (line_len[l] != H); ferr = 0;
      end else begin
        repeat (2) tick();
      end
    end
    if (live && n_lines != V) ferr = 1;
    repeat (2) tick();
    if (live) begin
      fc_model = fc_model + 16'd1;
      fd_q.push_back('{cnt: fc_model, sum: sum});
    end
    exp_lerr = lerr; exp_ferr = ferr;
  endtask

  initial begin
    reset = 1'b1; vs = 1'b1; blank_n = 1'b0; capture_en = 1'b0; err_clr = 1'b0;
    b_data = '0; g_data = '0; r_data = '0;
    exp_lerr = 0; exp_ferr = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    end_frame();

    // Clean full frame, with a known pixel at (5,2).
    set_uniform(V, H); mark_pixel = 1;
    run_frame(1'b1); end_frame();

    // Short lines; the second coincides with err_clr.
    set_uniform(V, H); line_len[3] = H - 1; line_len[6] = H - 1; clr_line = 6;
    run_frame(1'b1); end_frame();

    // One line short of a frame.
    set_uniform(V - 1, H);
    run_frame(1'b1); end_frame();

    // One extra line and one over-long line: writes beyond the frame are dropped.
    set_uniform(V + 1, H); line_len[4] = H + 2;
    run_frame(1'b1); end_frame();

    // capture_en low at vs rise; asserting it mid-frame changes nothing.
    set_uniform(V, H); toggle_cap = 1;
    run_frame(1'b0); end_frame();

    // capture_en dropped mid-frame does not abort the frame.
    set_uniform(V, H); toggle_cap = 1;
    run_frame(1'b1); end_frame();

    // Reset in the middle of a frame, then a clean frame afterwards.
    set_uniform(V, H); abort_line = 4;
    run_frame(1'b1); end_frame();
    set_uniform(V, H);
    run_frame(1'b1); end_frame();

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      set_uniform(V - 1 + int'($urandom_range(0, 2)), H);
      for (int l = 0; l < n_lines; l++)
        if ($urandom_range(0, 7) == 0) line_len[l] = H - 1 + 2 * int'($urandom_range(0, 1));
      run_frame($urandom_range(0, 3) != 0);
      end_frame();
    end

    repeat (10) tick();
    check("write queue drained", wr_q.size(), 0);
    check("frame_done queue drained", fd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
